// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, speed table and ramp state encoding.
// Used by vga_frame_timing and step_ramp (ramp FSM gated by STEP_RAMP_EN).
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned STEP_W = 12;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StUp   = 2'd1,
    StDown = 2'd2
  } ramp_state_e;

  // Target step in 8.4 fixed point; pause forces a stop.
  function automatic logic [STEP_W-1:0] speed_target(input logic [2:0] sel, input logic pause);
    logic [STEP_W-1:0] t;
    case (sel)
      3'd0:    t = 12'h000;
      3'd1:    t = 12'h008;
      3'd2:    t = 12'h010;
      3'd3:    t = 12'h020;
      3'd4:    t = 12'h040;
      3'd5:    t = 12'h080;
      3'd6:    t = 12'h100;
      default: t = 12'h200;
    endcase
    if (pause) begin
      t = '0;
    end
    return t;
  endfunction

endpackage

// File: rtl/step_ramp.sv
// step_size register; with STEP_RAMP_EN defined it slews toward the target by
// RAMP_STEP per tick (HOLD/UP/DOWN FSM), otherwise it loads the target directly.
module step_ramp
  import vga_timing_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [STEP_W-1:0] target,
  output logic [STEP_W-1:0] step
);

  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;

`ifdef STEP_RAMP_EN
  localparam logic [STEP_W-1:0] STEP_INC = STEP_W'(RAMP_STEP);

  ramp_state_e r_state;
  ramp_state_e w_state_nxt;

  // Clamp against the distance to target so the ramp never overshoots or wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (tick) begin
      if (r_step < target) begin
        w_state_nxt = StUp;
        w_step_nxt  = ((target - r_step) > STEP_INC) ? (r_step + STEP_INC) : target;
      end else if (r_step > target) begin
        w_state_nxt = StDown;
        w_step_nxt  = ((r_step - target) > STEP_INC) ? (r_step - STEP_INC) : target;
      end else begin
        w_state_nxt = StHold;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StHold;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end
`else
  logic [31:0] w_unused_ramp;
  assign w_unused_ramp = RAMP_STEP;

  always_comb begin
    w_step_nxt = r_step;
    if (tick) begin
      w_step_nxt = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
    end else begin
      r_step <= w_step_nxt;
    end
  end
`endif

  assign step = r_step;

endmodule

// File: rtl/vga_frame_timing.sv
// VGA sync/coordinate generator with per-frame tick and ramped step_size.
// Optional macro STEP_RAMP_EN enables the step ramp; otherwise step loads directly.
module vga_frame_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = H_ACTIVE_DEF,
  parameter int unsigned H_FP             = H_FP_DEF,
  parameter int unsigned H_SYNC           = H_SYNC_DEF,
  parameter int unsigned H_BP             = H_BP_DEF,
  parameter int unsigned V_ACTIVE         = V_ACTIVE_DEF,
  parameter int unsigned V_FP             = V_FP_DEF,
  parameter int unsigned V_SYNC           = V_SYNC_DEF,
  parameter int unsigned V_BP             = V_BP_DEF,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter int unsigned RAMP_STEP        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        speed_sel,
  input  logic              pause,
  output logic              hsync,
  output logic              vsync,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic              active,
  output logic              next_frame,
  output logic [STEP_W-1:0] step_size
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_OFF = ~SYNC_ACTIVE_HIGH;

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;

  logic       w_hs_on;
  logic       w_vs_on;
  logic       w_active;
  logic       w_frame;

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_active;
  logic       r_next_frame;
  logic       r_hsync;
  logic       r_vsync;

  logic [STEP_W-1:0] w_target;

  always_comb begin
    w_h_nxt = r_h_cnt + 10'd1;
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v_cnt == V_LAST) ? '0 : (r_v_cnt + 10'd1);
    end
  end

  // All decodes look at the current counter state so outputs stay mutually aligned.
  always_comb begin
    w_hs_on  = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    w_vs_on  = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_frame  = (r_h_cnt == '0) && (r_v_cnt == V_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_active     <= 1'b0;
      r_next_frame <= 1'b0;
      r_hsync      <= SYNC_OFF;
      r_vsync      <= SYNC_OFF;
    end else begin
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_x          <= r_h_cnt;
      r_y          <= r_v_cnt;
      r_active     <= w_active;
      r_next_frame <= w_frame;
      r_hsync      <= w_hs_on ^ SYNC_OFF;
      r_vsync      <= w_vs_on ^ SYNC_OFF;
    end
  end

  // Target is only consumed on the tick edge, so speed_sel/pause are sampled there.
  assign w_target = speed_target(speed_sel, pause);

  step_ramp #(
    .RAMP_STEP (RAMP_STEP)
  ) u_step_ramp (
    .clk    (clk),
    .rst    (rst),
    .tick   (r_next_frame),
    .target (w_target),
    .step   (step_size)
  );

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign x          = r_x;
  assign y          = r_y;
  assign active     = r_active;
  assign next_frame = r_next_frame;

endmodule

// File: tb/tb_vga_frame_timing.sv
// Directed bench for vga_frame_timing on a shrunken 20x10 raster (200 clocks/frame).
// Checks ramp behaviour when STEP_RAMP_EN is defined, direct loading otherwise.
module tb_vga_frame_timing;

  localparam int unsigned HA = 10;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 3;
  localparam int unsigned HB = 5;
  localparam int unsigned VA = 6;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  speed_sel;
  logic        pause;
  logic        hsync;
  logic        vsync;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic        next_frame;
  logic [11:0] step_size;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [11:0] s;

  vga_frame_timing #(
    .H_ACTIVE         (HA),
    .H_FP             (HF),
    .H_SYNC           (HS),
    .H_BP             (HB),
    .V_ACTIVE         (VA),
    .V_FP             (VF),
    .V_SYNC           (VS),
    .V_BP             (VB),
    .SYNC_ACTIVE_HIGH (1'b0),
    .RAMP_STEP        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .speed_sel  (speed_sel),
    .pause      (pause),
    .hsync      (hsync),
    .vsync      (vsync),
    .x          (x),
    .y          (y),
    .active     (active),
    .next_frame (next_frame),
    .step_size  (step_size)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for next_frame, then return step_size one clock later.
  task automatic frame_step(output logic [11:0] st);
    int n;
    n = 0;
    while (next_frame !== 1'b1 && n < 2 * HT * VT) begin
      @(negedge clk);
      n++;
    end
    if (next_frame !== 1'b1) begin
      check("next_frame_timeout", {31'd0, next_frame}, 32'd1);
    end
    @(negedge clk);
    st = step_size;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int ex, ey;
    int xy_err, act_err, act_cnt, hs_err, hs_low, vs_err, vs_low, nf_cnt, nf_x, nf_y;
    int n;
    logic [11:0] tbl [8];

    tbl = '{12'h000, 12'h008, 12'h010, 12'h020, 12'h040, 12'h080, 12'h100, 12'h200};
    rst       = 1'b1;
    speed_sel = 3'd0;
    pause     = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_active", active, 0);
    check("rst_next_frame", next_frame, 0);
    check("rst_step", step_size, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);

    rst = 1'b0;
    ex = 0; ey = 0;
    xy_err = 0; act_err = 0; act_cnt = 0; hs_err = 0; hs_low = 0;
    vs_err = 0; vs_low = 0; nf_cnt = 0; nf_x = -1; nf_y = -1;
    for (int i = 0; i < HT * VT; i++) begin
      @(negedge clk);
      if (x !== 10'(ex) || y !== 10'(ey)) xy_err++;
      if (active !== ((ex < HA) && (ey < VA))) act_err++;
      if (active === 1'b1) act_cnt++;
      if (hsync !== !((ex >= HA + HF) && (ex < HA + HF + HS))) hs_err++;
      if (hsync === 1'b0) hs_low++;
      if (vsync !== !((ey >= VA + VF) && (ey < VA + VF + VS))) vs_err++;
      if (vsync === 1'b0) vs_low++;
      if (next_frame === 1'b1) begin
        nf_cnt++;
        nf_x = int'(x);
        nf_y = int'(y);
      end
      ex++;
      if (ex == HT) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end
    end
    check("frame_xy_seq", xy_err, 0);
    check("frame_active_decode", act_err, 0);
    check("frame_active_count", act_cnt, HA * VA);
    check("frame_hsync_decode", hs_err, 0);
    check("frame_hsync_low", hs_low, HS * VT);
    check("frame_vsync_decode", vs_err, 0);
    check("frame_vsync_low", vs_low, VS * HT);
    check("frame_nf_count", nf_cnt, 1);
    check("frame_nf_x", nf_x, 0);
    check("frame_nf_y", nf_y, VA);

`ifdef STEP_RAMP_EN
    speed_sel = 3'd6;
    for (int k = 1; k <= 64; k++) begin
      frame_step(s);
      check($sformatf("ramp_up_f%0d", k), s, 32'(4 * k));
    end
    frame_step(s);
    check("ramp_up_hold", s, 32'h100);

    pause = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      frame_step(s);
      check($sformatf("ramp_pause_f%0d", k), s, 32'(256 - 4 * k));
    end
    frame_step(s);
    check("ramp_pause_floor", s, 32'h000);

    pause = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      frame_step(s);
      check($sformatf("ramp_resume_f%0d", k), s, 32'(4 * k));
    end

    speed_sel = 3'd1;
    for (int k = 1; k <= 6; k++) begin
      frame_step(s);
      check($sformatf("ramp_reverse_f%0d", k), s, 32'(32 - 4 * k));
    end
    frame_step(s);
    check("ramp_reverse_hold", s, 32'h008);

    speed_sel = 3'd7;
    repeat (50) @(negedge clk);
    check("ramp_mid_frame_stable", step_size, 32'h008);
    speed_sel = 3'd1;
`else
    speed_sel = 3'd7;
    frame_step(s);
    check("direct_first_sel7", s, 32'h200);
    for (int k = 0; k < 8; k++) begin
      speed_sel = 3'(k);
      frame_step(s);
      check($sformatf("direct_sel%0d", k), s, 32'(tbl[k]));
    end
    pause = 1'b1;
    frame_step(s);
    check("direct_pause", s, 32'h000);
    pause     = 1'b0;
    speed_sel = 3'd5;
    frame_step(s);
    check("direct_sel5", s, 32'h080);
    speed_sel = 3'd2;
    repeat (50) @(negedge clk);
    check("direct_mid_frame_stable", step_size, 32'h080);
    speed_sel = 3'd5;
`endif

    n = 0;
    while (!(x == 10'd5 && y == 10'd3) && n < 2 * HT * VT) begin
      @(negedge clk);
      n++;
    end
    check("reach_x5_y3", {12'd0, x, y}, {12'd0, 10'd5, 10'd3});
    rst = 1'b1;
    #1;
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_active", active, 0);
    check("midrst_next_frame", next_frame, 0);
    check("midrst_step", step_size, 0);
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_x%0d", i), x, i);
      check($sformatf("post_rst_y%0d", i), y, 0);
    end
    check("post_rst_step", step_size, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
